// File: rtl/act_quant_pipe.sv
// Two-stage activation + requantisation pipeline for LANES parallel MAC accumulators.
// S1 applies the activation and latches per-vector config; S2 shifts, rounds, saturates and clips.
module act_quant_pipe #(
    parameter int LANES       = 8,
    parameter int IN_WIDTH    = 36,
    parameter int OUT_WIDTH   = 16,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                         system_clk,
    input  logic                         rst_n,
    input  logic [LANES*IN_WIDTH-1:0]    in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [LANES*OUT_WIDTH-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic [1:0]                   act_mode,
    input  logic [3:0]                   fea_in_quant_size,
    input  logic [3:0]                   weight_quant_size,
    input  logic [3:0]                   fea_out_quant_size,
    input  logic                         round_en,
    input  logic [OUT_WIDTH-1:0]         clip_max,
    input  logic                         sat_clear,
    output logic [15:0]                  sat_count,
    output logic                         cfg_err
);

    localparam int SW = IN_WIDTH + 1;
    localparam int CW = $clog2(LANES + 1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                         r_s1_valid;
    logic [LANES*IN_WIDTH-1:0]    r_s1_data;
    logic [4:0]                   r_s1_shift;
    logic [1:0]                   r_s1_mode;
    logic                         r_s1_round;
    logic [OUT_WIDTH-1:0]         r_s1_clip;
    logic                         r_s2_valid;
    logic [LANES*OUT_WIDTH-1:0]   r_s2_data;
    logic [CW-1:0]                r_s2_nsat;
    logic [15:0]                  r_sat_count;
    logic                         r_cfg_err;

    logic                         w_s2_load;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_xfer;
    logic signed [5:0]            w_shift6;
    logic                         w_shift_neg;
    logic [4:0]                   w_shift5;
    logic signed [IN_WIDTH-1:0]   w_lane_in;
    logic signed [IN_WIDTH-1:0]   w_lane_act;
    logic [LANES*IN_WIDTH-1:0]    w_act_data;
    logic signed [SW-1:0]         w_round;
    logic signed [SW-1:0]         w_a;
    logic signed [SW-1:0]         w_y;
    logic                         w_sat;
    logic [OUT_WIDTH-1:0]         w_q;
    logic [LANES*OUT_WIDTH-1:0]   w_q_data;
    logic [CW-1:0]                w_q_nsat;
    logic [16:0]                  w_sat_sum;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_s2_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign sat_count = r_sat_count;
    assign cfg_err   = r_cfg_err;

    // Net shift can be negative (-15..30); it is clamped to 0 and flagged instead.
    assign w_shift6    = {2'b00, fea_in_quant_size} + {2'b00, weight_quant_size}
                       - {2'b00, fea_out_quant_size};
    assign w_shift_neg = w_shift6[5];
    assign w_shift5    = w_shift_neg ? 5'd0 : w_shift6[4:0];

    always_comb begin
        w_act_data = '0;
        w_lane_in  = '0;
        w_lane_act = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_lane_in = in_data[k*IN_WIDTH +: IN_WIDTH];
            case (act_mode)
                2'd0:    w_lane_act = w_lane_in;
                2'd2:    w_lane_act = w_lane_in[IN_WIDTH-1] ? (w_lane_in >>> LEAKY_SHIFT) : w_lane_in;
                default: w_lane_act = w_lane_in[IN_WIDTH-1] ? '0 : w_lane_in;
            endcase
            w_act_data[k*IN_WIDTH +: IN_WIDTH] = w_lane_act;
        end
    end

    always_comb begin
        w_q_data = '0;
        w_q_nsat = '0;
        w_a      = '0;
        w_y      = '0;
        w_sat    = 1'b0;
        w_q      = '0;
        w_round  = (r_s1_round && (r_s1_shift != 5'd0)) ? (SW'(1) <<< (r_s1_shift - 5'd1)) : '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_a   = {r_s1_data[k*IN_WIDTH + IN_WIDTH - 1], r_s1_data[k*IN_WIDTH +: IN_WIDTH]};
            w_y   = (w_a + w_round) >>> r_s1_shift;
            // Fits OUT_WIDTH only when every bit from the output sign upward agrees.
            w_sat = !((&w_y[SW-1:OUT_WIDTH-1]) || !(|w_y[SW-1:OUT_WIDTH-1]));
            w_q   = w_sat ? (w_y[SW-1] ? OUT_MIN : OUT_MAX) : w_y[OUT_WIDTH-1:0];
            if ((r_s1_mode == 2'd3) && (w_q > r_s1_clip))
                w_q = r_s1_clip;
            w_q_data[k*OUT_WIDTH +: OUT_WIDTH] = w_q;
            w_q_nsat = w_q_nsat + CW'(w_sat);
        end
    end

    assign w_sat_sum = {1'b0, r_sat_count} + 17'(r_s2_nsat);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_shift  <= '0;
            r_s1_mode   <= '0;
            r_s1_round  <= 1'b0;
            r_s1_clip   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_nsat   <= '0;
            r_sat_count <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (w_in_ready)
                r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_data  <= w_act_data;
                r_s1_shift <= w_shift5;
                r_s1_mode  <= act_mode;
                r_s1_round <= round_en;
                r_s1_clip  <= clip_max;
                if (w_shift_neg)
                    r_cfg_err <= 1'b1;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_q_data;
                    r_s2_nsat <= w_q_nsat;
                end
            end
            if (sat_clear)
                r_sat_count <= '0;
            else if (w_xfer)
                r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

endmodule

// File: tb/tb_act_quant_pipe.sv
// Self-checking bench for act_quant_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model of the activation/requantisation rules.
module tb_act_quant_pipe;

    localparam int L  = 8;
    localparam int IW = 36;
    localparam int OW = 16;
    localparam int LS = 3;

    logic                system_clk = 1'b0;
    logic                rst_n;
    logic [L*IW-1:0]     in_data;
    logic                in_valid;
    logic                in_ready;
    logic [L*OW-1:0]     out_data;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          act_mode;
    logic [3:0]          fea_in_quant_size;
    logic [3:0]          weight_quant_size;
    logic [3:0]          fea_out_quant_size;
    logic                round_en;
    logic [OW-1:0]       clip_max;
    logic                sat_clear;
    logic [15:0]         sat_count;
    logic                cfg_err;

    act_quant_pipe #(.LANES(L), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LEAKY_SHIFT(LS)) dut (
        .system_clk         (system_clk),
        .rst_n              (rst_n),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .act_mode           (act_mode),
        .fea_in_quant_size  (fea_in_quant_size),
        .weight_quant_size  (weight_quant_size),
        .fea_out_quant_size (fea_out_quant_size),
        .round_en           (round_en),
        .clip_max           (clip_max),
        .sat_clear          (sat_clear),
        .sat_count          (sat_count),
        .cfg_err            (cfg_err)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [L*OW-1:0] d;
        int              n;
    } exp_t;

    exp_t            q[$];
    int              checks   = 0;
    int              failures = 0;
    int              msat     = 0;
    logic            mcfg     = 1'b0;
    logic            held     = 1'b0;
    logic [L*OW-1:0] hd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the activation/quantisation rules.
    function automatic void model(input logic [L*IW-1:0] d, input logic [1:0] m,
                                  input logic [3:0] fi, input logic [3:0] w, input logic [3:0] fo,
                                  input logic rnd, input logic [15:0] clip,
                                  output logic [L*OW-1:0] o, output int nsat);
        int                   s;
        longint               x, a, y, rc;
        logic signed [IW-1:0] t;
        s = int'(fi) + int'(w) - int'(fo);
        if (s < 0) s = 0;
        nsat = 0;
        o    = '0;
        for (int k = 0; k < L; k++) begin
            t = d[k*IW +: IW];
            x = t;
            case (m)
                2'd0:    a = x;
                2'd2:    a = (x < 0) ? (x >>> LS) : x;
                default: a = (x < 0) ? 0 : x;
            endcase
            rc = (rnd && s > 0) ? (longint'(1) <<< (s - 1)) : 0;
            y  = (a + rc) >>> s;
            if (y > 32767) begin
                y = 32767;
                nsat++;
            end else if (y < -32768) begin
                y = -32768;
                nsat++;
            end
            if (m == 2'd3 && y > longint'(clip)) y = longint'(clip);
            o[k*OW +: OW] = y[15:0];
        end
    endfunction

    task automatic tick(output logic acc);
        logic xfer;
        exp_t e, f;
        #1;
        if (held) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, hd);
        end
        chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        chk("sat_count", sat_count, msat);
        chk("cfg_err", cfg_err, mcfg);
        xfer = out_valid && out_ready;
        acc  = in_valid && in_ready;
        if (xfer) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                f = q.pop_front();
                chk("out_data", out_data, f.d);
                msat = (msat + f.n > 65535) ? 65535 : msat + f.n;
            end
        end
        if (sat_clear) msat = 0;
        if (acc) begin
            model(in_data, act_mode, fea_in_quant_size, weight_quant_size, fea_out_quant_size,
                  round_en, clip_max, e.d, e.n);
            q.push_back(e);
            if (int'(fea_in_quant_size) + int'(weight_quant_size) - int'(fea_out_quant_size) < 0)
                mcfg = 1'b1;
        end
        held = out_valid && !out_ready;
        hd   = out_data;
        @(posedge system_clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        logic a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < maxc && q.size() != 0; c++) tick(a);
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [3:0] fi, input logic [3:0] w,
                           input logic [3:0] fo, input logic rnd, input logic [15:0] clip);
        act_mode           = m;
        fea_in_quant_size  = fi;
        weight_quant_size  = w;
        fea_out_quant_size = fo;
        round_en           = rnd;
        clip_max           = clip;
    endtask

    function automatic logic [L*IW-1:0] rnd_vec();
        logic [L*IW-1:0] v;
        logic [63:0]     t;
        for (int k = 0; k < L; k++) begin
            t = {$urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       v[k*IW +: IW] = t[35:0];
                1:       v[k*IW +: IW] = IW'(int'($urandom_range(0, 8191)) - 4096);
                default: v[k*IW +: IW] = IW'(longint'(t[27:0]) - (longint'(1) <<< 27));
            endcase
        end
        return v;
    endfunction

    function automatic logic [L*IW-1:0] sat_vec(input int nsat_lanes);
        logic [L*IW-1:0] v;
        v = '0;
        for (int k = 0; k < nsat_lanes; k++)
            v[k*IW +: IW] = (k % 2 == 0) ? 36'h7_FFFF_FFFF : 36'h8_0000_0000;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   acc_n;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clear = 1'b0;
        set_cfg(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_sat_count", sat_count, 16'd0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        #11 rst_n = 1'b1;
        @(posedge system_clk);
        #1;

        // ReLU with shift 8 and rounding
        set_cfg(2'd1, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0);
        in_data = '0;
        in_data[0*IW +: IW] = 36'h180;
        in_data[1*IW +: IW] = 36'(-1280);
        in_valid = 1'b1;
        tick(a);
        chk("r036_accept", a, 1'b1);
        chk("r036_lat1_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        tick(a);
        chk("r036_lat2_valid", out_valid, 1'b1);
        chk("r036_lane0", out_data[0*OW +: OW], 16'd2);
        chk("r036_lane1", out_data[1*OW +: OW], 16'd0);
        drain(10);
        chk("r036_sat", sat_count, 16'd0);

        // Leaky ReLU, shift 0, one saturating lane
        set_cfg(2'd2, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        in_data = '0;
        in_data[0*IW +: IW] = 36'(-64);
        in_data[1*IW +: IW] = 36'h7FF_FFFF;
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        tick(a);
        chk("r037_lane0", out_data[0*OW +: OW], 16'hFFF8);
        chk("r037_lane1", out_data[1*OW +: OW], 16'h7FFF);
        drain(10);
        chk("r037_sat", sat_count, 16'd1);

        // Clipped ReLU, shift 4, truncation
        set_cfg(2'd3, 4'd4, 4'd0, 4'd0, 1'b0, 16'd96);
        in_data = '0;
        in_data[0*IW +: IW] = 36'd2000;
        in_data[1*IW +: IW] = 36'(-2000);
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        tick(a);
        chk("r038_lane0", out_data[0*OW +: OW], 16'd96);
        chk("r038_lane1", out_data[1*OW +: OW], 16'd0);
        drain(10);

        // Negative net shift: clamped to 0, sticky error
        chk("r040_cfg_before", cfg_err, 1'b0);
        set_cfg(2'd0, 4'd2, 4'd2, 4'd12, 1'b1, 16'd0);
        in_data = '0;
        in_data[0*IW +: IW] = 36'h123;
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        chk("r040_cfg_set", cfg_err, 1'b1);
        tick(a);
        chk("r040_shift0_lane0", out_data[0*OW +: OW], 16'h0123);
        drain(10);
        set_cfg(2'd1, 4'd4, 4'd4, 4'd4, 1'b0, 16'd0);
        tick(a);
        chk("r040_cfg_sticky", cfg_err, 1'b1);

        // 10 vectors back-to-back, out_ready pattern 1,0,0,1
        acc_n = 0;
        in_data = rnd_vec();
        set_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom));
        for (int c = 0; c < 200 && acc_n < 10; c++) begin
            in_valid  = 1'b1;
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            tick(a);
            if (a) begin
                acc_n++;
                in_data = rnd_vec();
                set_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
        chk("stream_accepted", acc_n, 10);
        drain(50);

        // Randomized traffic with random backpressure and occasional clear
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            sat_clear = ($urandom_range(0, 19) == 0);
            in_data   = rnd_vec();
            set_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom));
            tick(a);
        end
        sat_clear = 1'b0;
        drain(50);

        // Saturation counter up to its ceiling
        sat_clear = 1'b1;
        tick(a);
        sat_clear = 1'b0;
        chk("satcnt_cleared", sat_count, 16'd0);
        set_cfg(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = sat_vec(8);
        for (int i = 0; i < 8191; i++) tick(a);
        in_data = sat_vec(6);
        tick(a);
        drain(10);
        chk("satcnt_fffe", sat_count, 16'hFFFE);
        in_data  = sat_vec(8);
        in_valid = 1'b1;
        tick(a);
        drain(10);
        chk("satcnt_ffff", sat_count, 16'hFFFF);
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        tick(a);
        chk("satclr_pre_valid", out_valid, 1'b1);
        sat_clear = 1'b1;
        tick(a);
        sat_clear = 1'b0;
        chk("satclr_priority", sat_count, 16'd0);
        drain(10);

        // Asynchronous reset with both stages full
        set_cfg(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd_vec();
        tick(a);
        in_data = rnd_vec();
        tick(a);
        chk("r041_full_valid", out_valid, 1'b1);
        chk("r041_full_ready", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("r041_async_valid", out_valid, 1'b0);
        chk("r041_async_data", out_data, '0);
        chk("r041_async_cfg", cfg_err, 1'b0);
        chk("r041_async_ready", in_ready, 1'b1);
        q.delete();
        msat = 0;
        mcfg = 1'b0;
        held = 1'b0;
        in_valid = 1'b0;
        @(posedge system_clk);
        @(posedge system_clk);
        #1;
        chk("r041_hold_in_reset", out_valid, 1'b0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        set_cfg(2'd1, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        in_data = '0;
        in_data[0*IW +: IW] = 36'd77;
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        chk("r041_post_lat1", out_valid, 1'b0);
        tick(a);
        chk("r041_post_lat2", out_valid, 1'b1);
        chk("r041_post_lane0", out_data[0*OW +: OW], 16'd77);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/act_quant_pipe.md
ACT_QUANT_PIPE -- requirements
Module: act_quant_pipe

Interface
REQ-001 SHALL have parameter LANES, default 8, number of parallel channels.
REQ-002 SHALL have parameter IN_WIDTH, default 36, signed MAC accumulator width per lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, signed output feature width per lane.
REQ-004 SHALL have parameter LEAKY_SHIFT, default 3, leaky-ReLU negative slope as 2^-LEAKY_SHIFT.
REQ-005 SHALL have port system_clk  in  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_data  in  LANES*IN_WIDTH  lane k at bits [k*IN_WIDTH +: IN_WIDTH], signed.
REQ-008 SHALL have port in_valid  in  1  in_data valid.
REQ-009 SHALL have port in_ready  out  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_data  out  LANES*OUT_WIDTH  lane k at bits [k*OUT_WIDTH +: OUT_WIDTH], signed.
REQ-011 SHALL have port out_valid  out  1  out_data valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts out_data.
REQ-013 SHALL have port act_mode  in  2  0 pass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
REQ-014 SHALL have ports fea_in_quant_size, weight_quant_size, fea_out_quant_size  in  4 each  fixed-point fraction bits.
REQ-015 SHALL have port round_en  in  1  round-half-up on right shift.
REQ-016 SHALL have port clip_max  in  OUT_WIDTH  upper bound for act_mode 3, unsigned, post-quant domain.
REQ-017 SHALL have port sat_clear  in  1  synchronous clear of sat_count.
REQ-018 SHALL have port sat_count  out  16  saturated-lane event counter.
REQ-019 SHALL have port cfg_err  out  1  sticky: negative shift sampled.

Function
REQ-020 SHALL be a 2-stage pipeline: S1 = activation, S2 = shift/round/saturate/clip; S1 and S2 each hold one valid flag plus LANES-wide data.
REQ-021 SHALL load S1 on in_valid && in_ready, sampling act_mode, quant sizes, round_en, clip_max into S1 alongside data.
REQ-022 SHALL compute s2_load = !s2_valid || out_ready; in_ready = !s1_valid || s2_load (combinational; no bubbles when out_ready held high).
REQ-023 SHALL give latency exactly 2 cycles from accepted input to out_valid with out_ready high; throughput 1 vector/cycle.
REQ-024 SHALL hold out_data and out_valid stable while out_valid && !out_ready; no loss, no duplication.
REQ-025 S1 activation per lane x: mode 0 x; mode 1/3 x<0 ? 0 : x; mode 2 x<0 ? x>>>LEAKY_SHIFT (arithmetic, lane's own sign) : x.
REQ-026 S1 SHALL compute shift = fea_in + weight - fea_out as signed 6-bit; shift<0 uses shift=0 and sets cfg_err.
REQ-027 S2 SHALL compute y = (a + (round_en && shift>0 ? 2^(shift-1) : 0)) >>> shift at IN_WIDTH+1 bits, no overflow.
REQ-028 S2 SHALL saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; mode 3 further clamps to min(y, clip_max).
REQ-029 A lane SHALL count as saturated when REQ-028 signed saturation altered it (clip_max clamp excluded).
REQ-030 sat_count SHALL add the number of saturated lanes on each out_valid && out_ready transfer, sticking at 16'hFFFF.
REQ-031 sat_clear SHALL zero sat_count, taking priority over a same-cycle increment.
REQ-032 cfg_err SHALL stay set until reset.
REQ-033 Config changes SHALL affect only vectors accepted after the change; in-flight vectors use sampled config.

Reset
REQ-034 On rst_n low, asynchronously: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, sat_count=0, cfg_err=0; in_ready=1 after reset.
REQ-035 Reset mid-operation SHALL discard in-flight vectors; first post-reset output is from first post-reset accepted input.

Verification
REQ-036 Mode 1, sizes 8/8/8 (shift 8), round_en=1, lane0=0x180, lane1=-0x500, out_ready=1 -> 2 cycles later lane0=2, lane1=0, sat_count unchanged.
REQ-037 Mode 2, shift 0, lane0=-64, LEAKY_SHIFT=3 -> lane0=-8; lane1=0x7FFFFFF -> 0x7FFF, sat_count += 1.
REQ-038 Mode 3, clip_max=96, shift 4, round_en=0, lane0=2000 -> 96; lane1=-2000 -> 0.
REQ-039 Stream 10 vectors back-to-back, out_ready toggles 1,0,0,1,... -> all 10 out in order, none dropped/duplicated, out_data stable while stalled, in_ready low only when both stages full and out_ready=0.
REQ-040 fea_out=12, fea_in=2, weight=2 -> cfg_err=1, shift 0 used; sat_count at 0xFFFE plus 8-lane saturation -> 0xFFFF; sat_clear same cycle -> 0.
REQ-041 Assert rst_n low with both stages valid -> out_valid=0 immediately; after release, output only from new inputs at latency 2.
